seg_frame_decoder: RTL and testbench
====================================

Name: seg_frame_decoder

Overview:
Receive side of the seven-segment display link: accepts a stream of 7-bit segment patterns (A..G, A = MSB) and converts each back to its 4-bit character code. Assembles NUM_CHARS characters into one frame word and reports a per-frame error flag plus a running error count. Sits after the display-pattern source in the encoding/decoding chain, so checkers can compare recovered codes against the originals.

Parameters:
NUM_CHARS, 4, characters per frame (2..8); char_word width = 4*NUM_CHARS
CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
seg_in  input  7  segment pattern {A,B,C,D,E,F,G}
seg_valid  input  1  seg_in valid this cycle
frame_start  input  1  qualified by seg_valid; marks the first character of a frame
char_word  output  4*NUM_CHARS  last completed frame; first char in the top nibble
word_valid  output  1  one-cycle pulse when char_word updates
frame_err  output  1  set if the completed frame held any unrecognised pattern; updates with char_word
err_count  output  CNT_W  total unrecognised patterns accepted, saturating
busy  output  1  high while in COLLECT

Behaviour:
- Reset: async, active-high. char_word = 0, word_valid = 0, frame_err = 0, err_count = 0, busy = 0, state = IDLE, index = 0, partial buffer = 0, partial error = 0.
- Pattern map (combinational, then registered):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - 0000001->1010 (dash), 0000000->1011 (blank), 1000111->1111 (F)
  - Any other pattern -> 1111 and flagged unrecognised.
- Accept = seg_valid high at clk edge. No backpressure: every accepted beat is consumed.
- States:
  - IDLE: beat with frame_start=1 -> store code at slot 0, index = 1, go COLLECT. Beats with frame_start=0 are discarded; unrecognised patterns in them still increment err_count.
  - COLLECT: beat with frame_start=0 -> store at slot[index], index+1. Beat with frame_start=1 -> discard the partial frame (no word_valid), restart at slot 0, index = 1.
  - When the beat filling slot NUM_CHARS-1 is accepted -> go IDLE, index = 0. On the next edge, load the full buffer into char_word, set frame_err = OR of the frame's unrecognised flags, and pulse word_valid for 1 cycle.
  - If NUM_CHARS is such that frame_start and the last slot coincide, frame_start takes priority (restart).
- Latency: word_valid is high exactly 1 cycle after the clk edge that accepted the last character. Back-to-back frames are allowed with no gap: the frame_start beat may arrive in the cycle right after the last beat.
- char_word and frame_err hold their values between word_valid pulses.
- err_count:
  - +1 per accepted unrecognised beat, in any state, including discarded or abandoned frames.
  - Holds at 2^CNT_W-1.
  - Cleared only by reset.
- busy = (state == COLLECT), registered.
- Idle gaps (seg_valid = 0) inside a frame are allowed and have no timeout.
- Reset mid-frame discards the partial frame; no word_valid is produced.

Test Plan:
- Reset, then 4 beats 0110000(fs=1), 1101101, 1111001, 0110011 -> next cycle word_valid=1 for 1 cycle, char_word=16'h1234, frame_err=0, err_count=0.
- Frame 1000111(fs=1), 0000001, 0000000, 1111110 -> char_word=16'hFAB0, frame_err=0.
- Frame with beat 2 = 0101010 (unrecognised) -> char_word nibble 2 = F, frame_err=1, err_count=1. A following clean frame -> frame_err=0, err_count stays 1.
- Two beats, then a new fs=1 beat followed by 3 more beats (random seg_valid gaps) -> no pulse for the abandoned frame; exactly one word_valid carrying the second frame.
- Beats 0110000 with fs=0 in IDLE -> no state change, busy=0, word_valid never asserted. 300 unrecognised beats -> err_count saturates at 8'hFF.
- Back-to-back frames with no gap -> two word_valid pulses 4 cycles apart. Assert reset after 2 beats of a third frame -> all outputs 0 immediately (async), no pulse.

Source files
------------

// File: rtl/seg_frame_decoder_if.sv
// Segment-pattern stream in, recovered character frame out.
// master = pattern source / checker side, slave = decoder.
interface seg_frame_decoder_if #(
    parameter int unsigned NUM_CHARS = 4,
    parameter int unsigned CNT_W     = 8
);
    logic [6:0]             seg_in;
    logic                   seg_valid;
    logic                   frame_start;
    logic [4*NUM_CHARS-1:0] char_word;
    logic                   word_valid;
    logic                   frame_err;
    logic [CNT_W-1:0]       err_count;
    logic                   busy;

    modport master (
        output seg_in, seg_valid, frame_start,
        input  char_word, word_valid, frame_err, err_count, busy
    );

    modport slave (
        input  seg_in, seg_valid, frame_start,
        output char_word, word_valid, frame_err, err_count, busy
    );
endinterface

// File: rtl/seg_frame_decoder.sv
// Seven-segment pattern decoder: maps patterns back to 4-bit codes and assembles
// NUM_CHARS codes into a frame word with a per-frame error flag and error counter.
module seg_frame_decoder #(
    parameter int unsigned NUM_CHARS = 4,
    parameter int unsigned CNT_W     = 8
) (
    input logic                clk,
    input logic                reset,
    seg_frame_decoder_if.slave bus
);
    localparam int unsigned     W       = 4 * NUM_CHARS;
    localparam int unsigned     IW      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IW-1:0]   LastIdx = IW'(NUM_CHARS - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic {StIdle, StCollect} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [W-1:0]      buf_q, buf_d;
    logic              perr_q, perr_d;
    logic              done_q, done_d;
    logic [W-1:0]      char_word_q;
    logic              word_valid_q;
    logic              frame_err_q;
    logic [CNT_W-1:0]  err_count_q;
    logic [3:0]        code;
    logic              unrec;

    always_comb begin
        code  = 4'hF;
        unrec = 1'b0;
        case (bus.seg_in)
            7'b1111110: code = 4'h0;
            7'b0110000: code = 4'h1;
            7'b1101101: code = 4'h2;
            7'b1111001: code = 4'h3;
            7'b0110011: code = 4'h4;
            7'b1011011: code = 4'h5;
            7'b1011111: code = 4'h6;
            7'b1110000: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1111011: code = 4'h9;
            7'b0000001: code = 4'hA;
            7'b0000000: code = 4'hB;
            7'b1000111: code = 4'hF;
            default: begin
                code  = 4'hF;
                unrec = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        perr_d  = perr_q;
        done_d  = 1'b0;
        if (bus.seg_valid) begin
            if (bus.frame_start) begin
                // A new frame start always wins, abandoning any partial frame.
                buf_d[W-1 -: 4] = code;
                perr_d          = unrec;
                idx_d           = IW'(1);
                state_d         = StCollect;
            end else if (state_q == StCollect) begin
                for (int i = 0; i < int'(NUM_CHARS); i++) begin
                    if (idx_q == IW'(i)) buf_d[4*(int'(NUM_CHARS)-1-i) +: 4] = code;
                end
                perr_d = perr_q | unrec;
                if (idx_q == LastIdx) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            buf_q        <= '0;
            perr_q       <= 1'b0;
            done_q       <= 1'b0;
            char_word_q  <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            perr_q       <= perr_d;
            done_q       <= done_d;
            word_valid_q <= done_q;
            // buf_q/perr_q still hold the finished frame even if a new one starts now.
            if (done_q) begin
                char_word_q <= buf_q;
                frame_err_q <= perr_q;
            end
            if (bus.seg_valid && unrec && (err_count_q != CntMax)) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign bus.char_word  = char_word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_count  = err_count_q;
    assign bus.busy       = (state_q == StCollect);
endmodule

// File: tb/tb_seg_frame_decoder.sv
// Directed bench for seg_frame_decoder (NUM_CHARS=4, CNT_W=8).
module tb_seg_frame_decoder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulse_cyc[$];
    logic [15:0] pulse_word[$];
    logic        pulse_err[$];

    seg_frame_decoder_if #(.NUM_CHARS(4), .CNT_W(8)) sif ();

    seg_frame_decoder #(.NUM_CHARS(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sif.word_valid === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_word.push_back(sif.char_word);
            pulse_err.push_back(sif.frame_err);
        end
    end

    task automatic beat(input logic [6:0] seg, input logic fs);
        @(negedge clk);
        sif.seg_in      = seg;
        sif.frame_start = fs;
        sif.seg_valid   = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sif.seg_valid   = 1'b0;
            sif.frame_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sif.seg_valid = 1'b0;
        sif.frame_start = 1'b0;
        sif.seg_in = 7'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sif.char_word !== 16'h0) begin
            errors++; $display("FAIL reset_char_word got %h want 0000", sif.char_word);
        end
        checks++;
        if (sif.word_valid !== 1'b0 || sif.frame_err !== 1'b0 || sif.busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags got wv=%b fe=%b busy=%b want 0 0 0",
                               sif.word_valid, sif.frame_err, sif.busy);
        end
        checks++;
        if (sif.err_count !== 8'h00) begin
            errors++; $display("FAIL reset_err_count got %h want 00", sif.err_count);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_digits();
        beat(7'b0110000, 1'b1);
        checks++;
        if (sif.busy !== 1'b0) begin
            errors++; $display("FAIL digits_busy_before got %b want 0", sif.busy);
        end
        beat(7'b1101101, 1'b0);
        checks++;
        if (sif.busy !== 1'b1) begin
            errors++; $display("FAIL digits_busy_collect got %b want 1", sif.busy);
        end
        beat(7'b1111001, 1'b0);
        beat(7'b0110011, 1'b0);
        idle(1);
        checks++;
        if (sif.word_valid !== 1'b0 || sif.busy !== 1'b0) begin
            errors++; $display("FAIL digits_early got wv=%b busy=%b want 0 0",
                               sif.word_valid, sif.busy);
        end
        idle(1);
        checks++;
        if (sif.word_valid !== 1'b1 || sif.char_word !== 16'h1234) begin
            errors++; $display("FAIL digits_word got wv=%b word=%h want 1 1234",
                               sif.word_valid, sif.char_word);
        end
        checks++;
        if (sif.frame_err !== 1'b0 || sif.err_count !== 8'h00) begin
            errors++; $display("FAIL digits_err got fe=%b cnt=%h want 0 00",
                               sif.frame_err, sif.err_count);
        end
        idle(1);
        checks++;
        if (sif.word_valid !== 1'b0 || sif.char_word !== 16'h1234) begin
            errors++; $display("FAIL digits_hold got wv=%b word=%h want 0 1234",
                               sif.word_valid, sif.char_word);
        end
    endtask

    task automatic test_symbols();
        beat(7'b1000111, 1'b1);
        beat(7'b0000001, 1'b0);
        beat(7'b0000000, 1'b0);
        beat(7'b1111110, 1'b0);
        idle(2);
        checks++;
        if (sif.word_valid !== 1'b1 || sif.char_word !== 16'hFAB0 || sif.frame_err !== 1'b0) begin
            errors++; $display("FAIL symbols got wv=%b word=%h fe=%b want 1 fab0 0",
                               sif.word_valid, sif.char_word, sif.frame_err);
        end
        idle(1);
    endtask

    task automatic test_unrec();
        beat(7'b0110000, 1'b1);
        beat(7'b1101101, 1'b0);
        beat(7'b0101010, 1'b0);
        beat(7'b0110011, 1'b0);
        idle(2);
        checks++;
        if (sif.word_valid !== 1'b1 || sif.char_word !== 16'h12F4 || sif.frame_err !== 1'b1) begin
            errors++; $display("FAIL unrec_frame got wv=%b word=%h fe=%b want 1 12f4 1",
                               sif.word_valid, sif.char_word, sif.frame_err);
        end
        checks++;
        if (sif.err_count !== 8'h01) begin
            errors++; $display("FAIL unrec_count got %h want 01", sif.err_count);
        end
        beat(7'b1111111, 1'b1);
        beat(7'b1111011, 1'b0);
        beat(7'b1011111, 1'b0);
        beat(7'b1110000, 1'b0);
        idle(2);
        checks++;
        if (sif.char_word !== 16'h8967 || sif.frame_err !== 1'b0 || sif.err_count !== 8'h01) begin
            errors++; $display("FAIL unrec_clean got word=%h fe=%b cnt=%h want 8967 0 01",
                               sif.char_word, sif.frame_err, sif.err_count);
        end
        idle(1);
    endtask

    task automatic test_abandon();
        int n0;
        n0 = pulse_cyc.size();
        beat(7'b0110000, 1'b1);
        idle(1);
        beat(7'b1101101, 1'b0);
        idle(2);
        beat(7'b1011011, 1'b1);
        idle(2);
        beat(7'b1110000, 1'b0);
        beat(7'b1111111, 1'b0);
        idle(3);
        beat(7'b1111011, 1'b0);
        idle(4);
        checks++;
        if (pulse_cyc.size() - n0 !== 1) begin
            errors++; $display("FAIL abandon_pulses got %0d want 1", pulse_cyc.size() - n0);
        end else begin
            checks++;
            if (pulse_word[n0] !== 16'h5789 || pulse_err[n0] !== 1'b0) begin
                errors++; $display("FAIL abandon_word got %h fe=%b want 5789 0",
                                   pulse_word[n0], pulse_err[n0]);
            end
        end
    endtask

    task automatic test_idle_discard();
        int n0;
        n0 = pulse_cyc.size();
        repeat (3) beat(7'b0110000, 1'b0);
        idle(1);
        checks++;
        if (sif.busy !== 1'b0 || sif.err_count !== 8'h01) begin
            errors++; $display("FAIL idle_discard got busy=%b cnt=%h want 0 01",
                               sif.busy, sif.err_count);
        end
        repeat (253) beat(7'b0101010, 1'b0);
        idle(1);
        checks++;
        if (sif.err_count !== 8'hFE) begin
            errors++; $display("FAIL sat_below got %h want fe", sif.err_count);
        end
        beat(7'b0101010, 1'b0);
        idle(1);
        checks++;
        if (sif.err_count !== 8'hFF) begin
            errors++; $display("FAIL sat_reach got %h want ff", sif.err_count);
        end
        repeat (46) beat(7'b0101010, 1'b0);
        idle(2);
        checks++;
        if (sif.err_count !== 8'hFF || sif.busy !== 1'b0) begin
            errors++; $display("FAIL sat_hold got cnt=%h busy=%b want ff 0",
                               sif.err_count, sif.busy);
        end
        checks++;
        if (pulse_cyc.size() !== n0) begin
            errors++; $display("FAIL idle_no_pulse got %0d want 0", pulse_cyc.size() - n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = pulse_cyc.size();
        beat(7'b0110000, 1'b1);
        beat(7'b1101101, 1'b0);
        beat(7'b1111001, 1'b0);
        beat(7'b0110011, 1'b0);
        beat(7'b1011011, 1'b1);
        beat(7'b1011111, 1'b0);
        beat(7'b1110000, 1'b0);
        beat(7'b1111111, 1'b0);
        beat(7'b0110000, 1'b1);
        beat(7'b1101101, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (sif.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy_third got %b want 1", sif.busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (sif.char_word !== 16'h0 || sif.word_valid !== 1'b0 || sif.frame_err !== 1'b0 ||
            sif.err_count !== 8'h00 || sif.busy !== 1'b0) begin
            errors++; $display("FAIL async_reset got word=%h wv=%b fe=%b cnt=%h busy=%b want all 0",
                               sif.char_word, sif.word_valid, sif.frame_err, sif.err_count,
                               sif.busy);
        end
        sif.seg_valid = 1'b0;
        sif.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(6);
        checks++;
        if (pulse_cyc.size() - n0 !== 2) begin
            errors++; $display("FAIL b2b_pulses got %0d want 2", pulse_cyc.size() - n0);
        end else begin
            checks++;
            if (pulse_cyc[n0+1] - pulse_cyc[n0] !== 4) begin
                errors++; $display("FAIL b2b_spacing got %0d want 4",
                                   pulse_cyc[n0+1] - pulse_cyc[n0]);
            end
            checks++;
            if (pulse_word[n0] !== 16'h1234 || pulse_word[n0+1] !== 16'h5678) begin
                errors++; $display("FAIL b2b_words got %h %h want 1234 5678",
                                   pulse_word[n0], pulse_word[n0+1]);
            end
        end
        checks++;
        if (sif.char_word !== 16'h0 || sif.busy !== 1'b0) begin
            errors++; $display("FAIL post_reset got word=%h busy=%b want 0000 0",
                               sif.char_word, sif.busy);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_symbols();
        test_unrec();
        test_abandon();
        test_idle_discard();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
